// File: rtl/pov_spi_loader.sv
// pov_spi_loader: SPI slave that captures six POV vectors into a shadow buffer
// and commits them to the live outputs on the vsync rising edge.
module pov_spi_loader #(
  parameter int QM          = 12,
  parameter int QN          = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     vsync,
  input  logic                     spi_sclk,
  input  logic                     spi_mosi,
  input  logic                     spi_cs_n,
  output logic signed [QM+QN-1:0]  playerX,
  output logic signed [QM+QN-1:0]  playerY,
  output logic signed [QM+QN-1:0]  facingX,
  output logic signed [QM+QN-1:0]  facingY,
  output logic signed [QM+QN-1:0]  vplaneX,
  output logic signed [QM+QN-1:0]  vplaneY,
  output logic                     o_pending,
  output logic                     o_frame_err
);
  localparam int W     = QM + QN;
  localparam int FRAME = 6 * W;
  localparam int CW    = $clog2(FRAME + 2);
  localparam logic [W-1:0] C_1P5 = W'(3) << (QN - 1);
  localparam logic [W-1:0] C_ONE = W'(1) << QN;
  localparam logic [W-1:0] C_MH  = -(W'(1) << (QN - 1));

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t r_state, w_next;

  logic [SYNC_STAGES-1:0] r_sclk_s, r_mosi_s, r_cs_s;
  logic [SYNC_STAGES:0]   r_fill;
  logic                   r_sclk_d, r_cs_d, r_vs_d;
  logic [FRAME-1:0]       r_shift, r_shadow;
  logic [CW-1:0]          r_cnt;
  logic w_sclk, w_mosi, w_cs, w_sclk_rise, w_cs_fall, w_cs_rise;
  logic w_start, w_end, w_load, w_commit;

  assign w_sclk      = r_sclk_s[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_s[SYNC_STAGES-1];
  assign w_cs        = r_cs_s[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  // r_fill keeps a cs_n that was already low at reset release from looking like a frame start
  assign w_cs_fall   = r_fill[SYNC_STAGES] & r_cs_d & ~w_cs;
  assign w_cs_rise   = ~r_cs_d & w_cs;
  assign w_load      = w_end & (r_cnt == CW'(FRAME));
  assign w_commit    = vsync & ~r_vs_d & o_pending;

  always_comb begin
    w_start = (r_state == IDLE) & w_cs_fall;
    w_end   = (r_state == SHIFT) & w_cs_rise;
    w_next  = w_start ? SHIFT : w_end ? IDLE : r_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sclk_s    <= '0;
      r_mosi_s    <= '0;
      r_cs_s      <= '1;
      r_fill      <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
      r_vs_d      <= 1'b0;
      r_shift     <= '0;
      r_shadow    <= '0;
      r_cnt       <= '0;
      o_pending   <= 1'b0;
      o_frame_err <= 1'b0;
      playerX     <= C_1P5;
      playerY     <= C_1P5;
      facingX     <= '0;
      facingY     <= C_ONE;
      vplaneX     <= C_MH;
      vplaneY     <= '0;
    end else begin
      r_sclk_s    <= {r_sclk_s[SYNC_STAGES-2:0], spi_sclk};
      r_mosi_s    <= {r_mosi_s[SYNC_STAGES-2:0], spi_mosi};
      r_cs_s      <= {r_cs_s[SYNC_STAGES-2:0], spi_cs_n};
      r_fill      <= {r_fill[SYNC_STAGES-1:0], 1'b1};
      r_sclk_d    <= w_sclk;
      r_cs_d      <= w_cs;
      r_vs_d      <= vsync;
      o_frame_err <= w_end & ~w_load;
      if (w_start) r_cnt <= '0;
      else if (r_state == SHIFT && w_sclk_rise) begin
        r_shift <= {r_shift[FRAME-2:0], w_mosi};
        if (r_cnt != CW'(FRAME + 1)) r_cnt <= r_cnt + 1'b1;
      end
      if (w_load) r_shadow <= r_shift;
      // commit reads the old shadow, so a same-cycle load waits for the next vsync
      if (w_commit) begin
        playerX <= r_shadow[6*W-1 -: W];
        playerY <= r_shadow[5*W-1 -: W];
        facingX <= r_shadow[4*W-1 -: W];
        facingY <= r_shadow[3*W-1 -: W];
        vplaneX <= r_shadow[2*W-1 -: W];
        vplaneY <= r_shadow[W-1 -: W];
      end
      o_pending <= w_load | (o_pending & ~w_commit);
    end
  end
endmodule

// File: tb/tb_pov_spi_loader.sv
// tb_pov_spi_loader: directed checks of frame capture, length errors,
// vsync commit timing and reset behaviour of pov_spi_loader.
module tb_pov_spi_loader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic vsync = 1'b0;
  logic spi_sclk = 1'b0;
  logic spi_mosi = 1'b0;
  logic spi_cs_n = 1'b1;
  logic signed [23:0] playerX, playerY, facingX, facingY, vplaneX, vplaneY;
  logic o_pending, o_frame_err;
  int checks = 0;
  int errors = 0;
  int err_cnt = 0;

  localparam logic [143:0] F1 = {24'h002000, 24'h003000, 24'h001000, 24'h000000, 24'h000000, 24'h000800};
  localparam logic [143:0] F2 = {24'h001000, 24'h003000, 24'h001000, 24'h000000, 24'h000000, 24'h000800};
  localparam logic [143:0] F3 = {24'h004000, 24'h005000, 24'h000000, 24'h001000, 24'hFFF000, 24'h000000};
  localparam logic [143:0] F4 = {24'h006000, 24'h006000, 24'h000000, 24'hFFF000, 24'h000800, 24'h000000};
  localparam logic [143:0] F5 = {24'h00A000, 24'h00B000, 24'h001000, 24'h000000, 24'h000000, 24'h001000};

  pov_spi_loader dut (
    .clk(clk), .reset(reset), .vsync(vsync),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .playerX(playerX), .playerY(playerY), .facingX(facingX),
    .facingY(facingY), .vplaneX(vplaneX), .vplaneY(vplaneY),
    .o_pending(o_pending), .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  // counts high cycles, so a pulse wider than one cycle shows up as extra counts
  always @(negedge clk) if (o_frame_err === 1'b1) err_cnt++;

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [143:0] f);
    chk({tag, " playerX"}, playerX, f[143:120]);
    chk({tag, " playerY"}, playerY, f[119:96]);
    chk({tag, " facingX"}, facingX, f[95:72]);
    chk({tag, " facingY"}, facingY, f[71:48]);
    chk({tag, " vplaneX"}, vplaneX, f[47:24]);
    chk({tag, " vplaneY"}, vplaneY, f[23:0]);
  endtask

  task automatic shift_bits(input logic [143:0] f, input int n);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      spi_mosi = (i < 144) ? f[143 - i] : 1'b0;
      repeat (4) @(negedge clk);
      spi_sclk = 1'b1;
      repeat (4) @(negedge clk);
      spi_sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic close_cs();
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic vs_up();
    vsync = 1'b1;
    @(negedge clk);
  endtask

  task automatic vs_down();
    vsync = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [143:0] rst_v;
    rst_v = {24'h001800, 24'h001800, 24'h000000, 24'h001000, 24'hFFF800, 24'h000000};
    repeat (3) @(negedge clk);
    chk_all("reset", rst_v);
    chk("reset pending", 24'(o_pending), 24'h0);
    chk("reset frame_err", 24'(o_frame_err), 24'h0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    shift_bits(F1, 144);
    close_cs();
    chk("f1 pending", 24'(o_pending), 24'h1);
    chk_all("f1 before vsync", rst_v);
    chk("f1 no err", 24'(err_cnt), 24'd0);
    vs_up();
    chk_all("f1 commit", F1);
    chk("f1 pending cleared", 24'(o_pending), 24'h0);
    vs_down();

    shift_bits(F3, 143);
    close_cs();
    chk("short err count", 24'(err_cnt), 24'd1);
    chk("short pending", 24'(o_pending), 24'h0);
    shift_bits(F3, 145);
    close_cs();
    chk("long err count", 24'(err_cnt), 24'd2);
    chk("long pending", 24'(o_pending), 24'h0);
    vs_up();
    vs_down();
    chk_all("bad frames ignored", F1);

    shift_bits(F2, 144);
    close_cs();
    shift_bits(F3, 144);
    close_cs();
    chk("two frames pending", 24'(o_pending), 24'h1);
    vs_up();
    chk_all("last frame wins", F3);
    shift_bits(F4, 144);
    close_cs();
    chk("vsync held pending", 24'(o_pending), 24'h1);
    chk("vsync held no commit", playerX, 24'h004000);
    vs_down();
    vs_up();
    chk_all("f4 commit", F4);
    vs_down();

    shift_bits(F5, 144);
    spi_cs_n = 1'b1;
    repeat (2) @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    chk("coincident no commit", playerX, 24'h006000);
    chk("coincident pending", 24'(o_pending), 24'h1);
    repeat (6) @(negedge clk);
    chk("coincident held", playerX, 24'h006000);
    vs_down();
    vs_up();
    chk_all("coincident next vsync", F5);
    chk("coincident pending cleared", 24'(o_pending), 24'h0);
    vs_down();
    chk("no stray err", 24'(err_cnt), 24'd2);

    shift_bits(F1, 70);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk_all("mid-frame reset", rst_v);
    chk("mid-frame reset pending", 24'(o_pending), 24'h0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    close_cs();
    chk("cs low at reset no frame", 24'(err_cnt), 24'd2);
    chk("cs low at reset pending", 24'(o_pending), 24'h0);
    shift_bits(F1, 144);
    close_cs();
    vs_up();
    chk_all("post-reset commit", F1);
    vs_down();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
